// File: rtl/cfg_stream_packer.sv
// Packs a 32-bit configuration bitstream into wide beats for a partial-reconfiguration
// controller, with optional ICAP byte swapping, packet word counting and a tkeep error flag.
module cfg_stream_packer #(
    parameter int unsigned SWAP_BYTES = 1,
    parameter int unsigned OUT_WIDTH  = 256,
    parameter int unsigned CNT_WIDTH  = 24
) (
    input  logic                   sys_clk,
    input  logic                   sys_resetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [31:0]            s_axis_tdata,
    input  logic [3:0]             s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [OUT_WIDTH-1:0]   m_axis_tdata,
    output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   config_start,
    output logic [CNT_WIDTH-1:0]   pkt_words,
    output logic                   keep_err,
    input  logic                   err_clr
);

    localparam int unsigned WPB   = OUT_WIDTH / 32;
    localparam int unsigned KW    = OUT_WIDTH / 8;
    localparam int unsigned IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 accept_c;
    logic                 beat_done_c;
    logic [31:0]          word_c;
    logic [3:0]           keep_c;
    logic [OUT_WIDTH-1:0] acc_data;
    logic [OUT_WIDTH-1:0] beat_data_c;
    logic [KW-1:0]        acc_keep;
    logic [KW-1:0]        beat_keep_c;
    logic [IDX_W-1:0]     idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

    // The output register is the only stall point: a word is taken whenever the beat slot can drain.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept_c      = s_axis_tvalid && s_axis_tready;

    generate
        if (SWAP_BYTES != 0) begin : g_swap
            assign word_c = {s_axis_tdata[7:0], s_axis_tdata[15:8],
                             s_axis_tdata[23:16], s_axis_tdata[31:24]};
            assign keep_c = {s_axis_tkeep[0], s_axis_tkeep[1],
                             s_axis_tkeep[2], s_axis_tkeep[3]};
        end else begin : g_noswap
            assign word_c = s_axis_tdata;
            assign keep_c = s_axis_tkeep;
        end
    endgenerate

    // Accumulator with the current word merged into lane idx.
    always_comb begin
        beat_data_c = acc_data;
        beat_keep_c = acc_keep;
        for (int k = 0; k < int'(WPB); k++) begin
            if (idx == IDX_W'(k)) begin
                beat_data_c[32*k +: 32] = word_c;
                beat_keep_c[4*k +: 4]   = keep_c;
            end
        end
        beat_done_c = accept_c && (s_axis_tlast || (idx == IDX_W'(WPB - 1)));
        cnt_inc_c   = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c && !s_axis_tlast) state_next = PKT;
            PKT:     if (accept_c && s_axis_tlast)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            idx           <= '0;
            acc_data      <= '0;
            acc_keep      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (beat_done_c) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= beat_data_c;
                m_axis_tkeep  <= beat_keep_c;
                m_axis_tlast  <= s_axis_tlast;
                idx           <= '0;
                acc_data      <= '0;
                acc_keep      <= '0;
            end else begin
                if (m_axis_tvalid && m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
                if (accept_c) begin
                    acc_data <= beat_data_c;
                    acc_keep <= beat_keep_c;
                    idx      <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Bitstream bookkeeping: start pulse, saturating word count, sticky keep error.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            config_start <= 1'b0;
            cnt          <= '0;
            pkt_words    <= '0;
            keep_err     <= 1'b0;
        end else begin
            config_start <= accept_c && (state == IDLE);
            if (accept_c) begin
                if (s_axis_tlast) begin
                    pkt_words <= cnt_inc_c;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc_c;
                end
            end
            if (accept_c && (s_axis_tkeep != 4'hF)) begin
                keep_err <= 1'b1;
            end else if (err_clr) begin
                keep_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cfg_stream_packer.md
CFG_STREAM_PACKER -- requirements
Module: cfg_stream_packer

Interface
REQ-001 SHALL have parameter SWAP_BYTES, default 1, meaning reverse byte order within each 32-bit input word (ICAP bit order) when 1.
REQ-002 SHALL have parameter OUT_WIDTH, default 256, meaning output stream data width: a multiple of 32 and at least 64 (WPB = OUT_WIDTH/32 words per beat).
REQ-003 SHALL have parameter CNT_WIDTH, default 24, meaning packet word-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, exactly as follows: sys_clk input 1 (sole clock; all state on the rising edge); sys_resetn input 1 (asynchronous assert, active-low).
REQ-005 SHALL have port s_axis_tvalid input 1, upstream DMA word valid.
REQ-006 SHALL have port s_axis_tready output 1, word accepted when high with tvalid.
REQ-007 SHALL have port s_axis_tdata input 32, bitstream word.
REQ-008 SHALL have port s_axis_tkeep input 4, byte enables.
REQ-009 SHALL have port s_axis_tlast input 1, final word of the bitstream.
REQ-010 SHALL have port m_axis_tvalid output 1, packed beat valid; feeds the PR controller stream slave.
REQ-011 SHALL have port m_axis_tready input 1, downstream accepts beat.
REQ-012 SHALL have port m_axis_tdata output OUT_WIDTH, packed beat.
REQ-013 SHALL have port m_axis_tkeep output OUT_WIDTH/8, packed byte enables.
REQ-014 SHALL have port m_axis_tlast output 1, final beat of the bitstream.
REQ-015 SHALL have port config_start output 1, one-cycle pulse on the first accepted word of a bitstream.
REQ-016 SHALL have port pkt_words output CNT_WIDTH, word count of the last completed bitstream.
REQ-017 SHALL have port keep_err output 1, sticky flag for a partial tkeep.
REQ-018 SHALL have port err_clr input 1, pulse that clears keep_err.

Function
REQ-019 SHALL implement states IDLE (no bitstream open) and PKT (bitstream open); IDLE->PKT on an accepted word with tlast=0; PKT->IDLE on an accepted word with tlast=1; a single-word bitstream (tlast=1 in IDLE) stays in IDLE.
REQ-020 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational; no other stall source).
REQ-021 SHALL place the k-th accepted word of a beat (k = 0..WPB-1, fill index idx) at m_axis_tdata[32k+31:32k] and its tkeep at m_axis_tkeep[4k+3:4k]; lanes not written in a beat SHALL be zero data and zero keep.
REQ-022 SHALL byte-reverse each word ({b0,b1,b2,b3}) before packing when SWAP_BYTES=1, and reverse its tkeep bits correspondingly.
REQ-023 SHALL load the output register and set m_axis_tvalid on the cycle after an accepted word with idx=WPB-1 or tlast=1, then reset idx to 0 and clear the accumulator; m_axis_tlast SHALL equal the tlast of that word.
REQ-024 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; clear m_axis_tvalid on handshake unless a new beat is loaded in the same cycle (back-to-back beats with no bubble).
REQ-025 SHALL pulse config_start for exactly one cycle, registered, the cycle after an accepted word in state IDLE.
REQ-026 SHALL count accepted words per bitstream, saturating at 2^CNT_WIDTH-1; on the tlast word SHALL load pkt_words with the final count (including that word) and zero the running count.
REQ-027 SHALL set keep_err on any accepted word with tkeep != 4'hF; the word SHALL still be passed through with its tkeep; err_clr SHALL clear it, and a set event in the same cycle SHALL win over err_clr.
REQ-028 SHALL ignore s_axis_tdata/tkeep/tlast whenever no handshake occurs.

Reset
REQ-029 SHALL on sys_resetn=0, asynchronously, force state IDLE, idx=0, accumulator=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, config_start=0, pkt_words=0, running count=0, keep_err=0; a partially filled beat is discarded.
REQ-030 SHALL, after reset release, treat the next accepted word as the start of a new bitstream.

Verification
REQ-031 SHALL cover: 16 words 0x00010203..., tlast on word 16, SWAP_BYTES=1, ready=1 -> two beats, word0 lane0 = 0x03020100, tkeep all ones, tlast on beat 2 only, config_start one pulse, pkt_words=16.
REQ-032 SHALL cover: 11 words with tlast -> beat 2 has tkeep=32'h00000FFF, upper lanes zero, pkt_words=11.
REQ-033 SHALL cover: m_axis_tready held low 5 cycles with a beat pending -> s_axis_tready=0 and output stable; on release, a continuous stream resumes at 1 word/cycle with no loss.
REQ-034 SHALL cover: a single word with tlast in IDLE -> one beat, tkeep=32'h0000000F, tlast=1, config_start pulse, pkt_words=1.
REQ-035 SHALL cover: a word with tkeep=4'h3 -> keep_err=1 and held; err_clr coincident with a new bad word -> stays 1; err_clr alone -> 0.
REQ-036 SHALL cover: sys_resetn asserted after 5 words -> outputs zero immediately; a subsequent 8-word bitstream yields one clean beat with a fresh config_start.
